// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-ported memory between the fetch and data ports; data has priority.
// Latency: a request seen in IDLE drives omem_req next cycle; gnt/rvalid/rdata pass through combinationally.
// Backpressure: grants withheld until memory accepts, one transaction outstanding; RISCV_ARB_STARVE_GUARD_EN bounds fetch starvation.
module riscv_mem_arbiter #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_STARVE_MAX = 4
) (
    input  logic                     iclk,
    input  logic                     irstn,
    input  logic                     iif_req,
    input  logic [31:0]              iif_addr,
    output logic                     oif_gnt,
    output logic                     oif_rvalid,
    output logic [MP_DATA_WIDTH-1:0] oif_rdata,
    input  logic                     idm_req,
    input  logic                     idm_we,
    input  logic [1:0]               idm_size,
    input  logic [31:0]              idm_addr,
    input  logic [MP_DATA_WIDTH-1:0] idm_wdata,
    output logic                     odm_gnt,
    output logic                     odm_rvalid,
    output logic [MP_DATA_WIDTH-1:0] odm_rdata,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [1:0]               omem_size,
    output logic [31:0]              omem_addr,
    output logic [MP_DATA_WIDTH-1:0] omem_wdata,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0] imem_rdata
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic       OWN_IF     = 1'b0;
    localparam logic       OWN_DM     = 1'b1;
    localparam logic [3:0] STARVE_MAX = 4'(MP_STARVE_MAX);

    state_t                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     we_q, we_d;
    logic [1:0]               size_q, size_d;
    logic [31:0]              addr_q, addr_d;
    logic [MP_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                     starve_hit;

`ifdef RISCV_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    // Counts data grants that overtook a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (odm_gnt && iif_req) begin
            starve_d = starve_q + 4'd1;
        end else if (odm_gnt || oif_gnt) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_hit = (starve_q == STARVE_MAX);
`else
    // Strict data priority: constant 0 for any legal MP_STARVE_MAX.
    assign starve_hit = (STARVE_MAX == 4'd0);
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        omem_req   = 1'b0;
        omem_we    = 1'b0;
        omem_size  = '0;
        omem_addr  = '0;
        omem_wdata = '0;
        oif_gnt    = 1'b0;
        odm_gnt    = 1'b0;
        oif_rvalid = 1'b0;
        odm_rvalid = 1'b0;
        oif_rdata  = '0;
        odm_rdata  = '0;
        case (state_q)
            IDLE: begin
                if (iif_req && (!idm_req || starve_hit)) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    size_d  = 2'b10;
                    addr_d  = iif_addr;
                    wdata_d = '0;
                    state_d = REQ;
                end else if (idm_req) begin
                    owner_d = OWN_DM;
                    we_d    = idm_we;
                    size_d  = idm_size;
                    addr_d  = idm_addr;
                    wdata_d = idm_wdata;
                    state_d = REQ;
                end
            end
            REQ: begin
                omem_req   = 1'b1;
                omem_we    = we_q;
                omem_size  = size_q;
                omem_addr  = addr_q;
                omem_wdata = wdata_q;
                if (imem_gnt) begin
                    oif_gnt = (owner_q == OWN_IF);
                    odm_gnt = (owner_q == OWN_DM);
                    state_d = we_q ? IDLE : RSP;
                end
            end
            RSP: begin
                if (imem_rvalid) begin
                    if (owner_q == OWN_DM) begin
                        odm_rvalid = 1'b1;
                        odm_rdata  = imem_rdata;
                    end else begin
                        oif_rvalid = 1'b1;
                        oif_rdata  = imem_rdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Honours RISCV_ARB_STARVE_GUARD_EN when choosing the expected arbitration outcome.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int AOW  = 3*DW + 40;
`ifdef RISCV_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          iclk = 1'b0;
    logic          irstn;
    logic          iif_req;
    logic [31:0]   iif_addr;
    logic          oif_gnt, oif_rvalid;
    logic [DW-1:0] oif_rdata;
    logic          idm_req, idm_we;
    logic [1:0]    idm_size;
    logic [31:0]   idm_addr;
    logic [DW-1:0] idm_wdata;
    logic          odm_gnt, odm_rvalid;
    logic [DW-1:0] odm_rdata;
    logic          omem_req, omem_we;
    logic [1:0]    omem_size;
    logic [31:0]   omem_addr;
    logic [DW-1:0] omem_wdata;
    logic          imem_gnt, imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic [AOW-1:0] all_out;

    int n_cmp = 0;
    int n_err = 0;

    assign all_out = {oif_gnt, oif_rvalid, oif_rdata, odm_gnt, odm_rvalid, odm_rdata,
                      omem_req, omem_we, omem_size, omem_addr, omem_wdata};

    always #5 iclk = ~iclk;

    riscv_mem_arbiter #(.MP_DATA_WIDTH(DW), .MP_STARVE_MAX(SMAX)) dut (
        .iclk(iclk), .irstn(irstn),
        .iif_req(iif_req), .iif_addr(iif_addr), .oif_gnt(oif_gnt),
        .oif_rvalid(oif_rvalid), .oif_rdata(oif_rdata),
        .idm_req(idm_req), .idm_we(idm_we), .idm_size(idm_size), .idm_addr(idm_addr),
        .idm_wdata(idm_wdata), .odm_gnt(odm_gnt), .odm_rvalid(odm_rvalid), .odm_rdata(odm_rdata),
        .omem_req(omem_req), .omem_we(omem_we), .omem_size(omem_size), .omem_addr(omem_addr),
        .omem_wdata(omem_wdata), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata)
    );

    task automatic clear_inputs();
        iif_req = 0; iif_addr = '0; idm_req = 0; idm_we = 0; idm_size = '0;
        idm_addr = '0; idm_wdata = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge iclk); irstn = 0; clear_inputs();
        @(negedge iclk); irstn = 1;
    endtask

    task automatic test_reset();
        @(negedge iclk);
        irstn = 0; iif_req = 1; iif_addr = 32'h80; imem_gnt = 1; imem_rvalid = 1; imem_rdata = '1;
        #1; n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL rst_outs: got %h want 0", all_out); end
        @(negedge iclk); #1; n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL rst_held: got %h want 0", all_out); end
        @(negedge iclk); irstn = 1; imem_gnt = 0; imem_rvalid = 0;
        #1; n_cmp++;
        if (omem_req !== 1'b0) begin n_err++; $display("FAIL rst_rel_idle: got %b want 0", omem_req); end
        @(negedge iclk); #1; n_cmp++;
        if ({omem_req, omem_we, omem_addr} !== {1'b1, 1'b0, 32'h80}) begin
            n_err++; $display("FAIL rst_first_arb: got %h want %h", {omem_req, omem_we, omem_addr}, {1'b1, 1'b0, 32'h80});
        end
    endtask

    task automatic test_fetch_only();
        @(negedge iclk); iif_req = 1; iif_addr = 32'h100; imem_gnt = 1;
        #1; n_cmp++;
        if ({omem_req, oif_gnt} !== 2'b00) begin n_err++; $display("FAIL fetch_c0: got %b want 00", {omem_req, oif_gnt}); end
        @(negedge iclk); #1; n_cmp++;
        if ({omem_req, omem_we, omem_size, omem_addr, oif_gnt, odm_gnt} !== {1'b1, 1'b0, 2'b10, 32'h100, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL fetch_c1: got %h want %h", {omem_req, omem_we, omem_size, omem_addr, oif_gnt, odm_gnt},
                              {1'b1, 1'b0, 2'b10, 32'h100, 1'b1, 1'b0});
        end
        @(negedge iclk); iif_req = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00500093;
        #1; n_cmp++;
        if ({oif_rvalid, oif_rdata} !== {1'b1, 32'h00500093}) begin
            n_err++; $display("FAIL fetch_rdata: got %h want %h", {oif_rvalid, oif_rdata}, {1'b1, 32'h00500093});
        end
        n_cmp++;
        if ({odm_gnt, odm_rvalid, odm_rdata, omem_req} !== '0) begin
            n_err++; $display("FAIL fetch_dm_quiet: got %h want 0", {odm_gnt, odm_rvalid, odm_rdata, omem_req});
        end
        @(negedge iclk); clear_inputs();
    endtask

    task automatic test_write();
        @(negedge iclk);
        idm_req = 1; idm_we = 1; idm_size = 2'b10; idm_addr = 32'h2000; idm_wdata = 32'hDEADBEEF; imem_gnt = 1;
        @(negedge iclk); #1; n_cmp++;
        if ({omem_req, omem_we, omem_size, omem_addr, omem_wdata, odm_gnt, oif_gnt} !==
            {1'b1, 1'b1, 2'b10, 32'h2000, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL wr_issue: got %h want %h", {omem_req, omem_we, omem_size, omem_addr, omem_wdata, odm_gnt, oif_gnt},
                              {1'b1, 1'b1, 2'b10, 32'h2000, 32'hDEADBEEF, 1'b1, 1'b0});
        end
        @(negedge iclk);
        idm_addr = 32'h2008; idm_wdata = 32'h12345678; imem_rvalid = 1;
        #1; n_cmp++;
        if ({oif_rvalid, odm_rvalid, omem_req} !== 3'b000) begin
            n_err++; $display("FAIL wr_no_rsp: got %b want 000", {oif_rvalid, odm_rvalid, omem_req});
        end
        @(negedge iclk); imem_rvalid = 0;
        #1; n_cmp++;
        if ({omem_req, omem_addr, odm_gnt} !== {1'b1, 32'h2008, 1'b1}) begin
            n_err++; $display("FAIL wr_idle_after2: got %h want %h", {omem_req, omem_addr, odm_gnt}, {1'b1, 32'h2008, 1'b1});
        end
        @(negedge iclk); clear_inputs();
    endtask

    task automatic test_collision();
        @(negedge iclk);
        iif_req = 1; iif_addr = 32'h104; idm_req = 1; idm_we = 0; idm_size = 2'b10; idm_addr = 32'h2004; imem_gnt = 1;
        @(negedge iclk); #1; n_cmp++;
        if ({omem_addr, omem_we, odm_gnt, oif_gnt} !== {32'h2004, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL col_dm_first: got %h want %h", {omem_addr, omem_we, odm_gnt, oif_gnt}, {32'h2004, 1'b0, 1'b1, 1'b0});
        end
        @(negedge iclk); idm_req = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hA5A5_0001;
        #1; n_cmp++;
        if ({odm_rvalid, odm_rdata, oif_rvalid} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin
            n_err++; $display("FAIL col_dm_rsp: got %h want %h", {odm_rvalid, odm_rdata, oif_rvalid}, {1'b1, 32'hA5A5_0001, 1'b0});
        end
        @(negedge iclk); imem_rvalid = 0; imem_gnt = 1;
        #1; n_cmp++;
        if ({omem_req, oif_gnt} !== 2'b00) begin n_err++; $display("FAIL col_idle: got %b want 00", {omem_req, oif_gnt}); end
        @(negedge iclk); #1; n_cmp++;
        if ({omem_req, omem_addr, oif_gnt, odm_gnt} !== {1'b1, 32'h104, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL col_if_issue: got %h want %h", {omem_req, omem_addr, oif_gnt, odm_gnt}, {1'b1, 32'h104, 1'b1, 1'b0});
        end
        @(negedge iclk); iif_req = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0513;
        #1; n_cmp++;
        if ({oif_rvalid, oif_rdata, odm_rvalid} !== {1'b1, 32'h0000_0513, 1'b0}) begin
            n_err++; $display("FAIL col_if_rsp: got %h want %h", {oif_rvalid, oif_rdata, odm_rvalid}, {1'b1, 32'h0000_0513, 1'b0});
        end
        @(negedge iclk); clear_inputs();
    endtask

    task automatic test_starvation();
        int dgr = 0;
        int fgr = 0;
        int exp_d, exp_f;
        @(negedge iclk);
        iif_req = 1; iif_addr = 32'h200; idm_req = 1; idm_we = 1; idm_size = 2'b10; idm_addr = 32'h3000;
        imem_gnt = 1; imem_rvalid = 1;
        for (int c = 0; c < 80; c++) begin
            @(negedge iclk); #1;
            if (odm_gnt === 1'b1) dgr++;
            if (oif_gnt === 1'b1) fgr++;
            if (fgr != 0 || dgr >= 20) break;
        end
        exp_d = GUARD ? SMAX : 20;
        exp_f = GUARD ? 1 : 0;
        n_cmp++;
        if (dgr != exp_d) begin n_err++; $display("FAIL starve_dm_grants: got %0d want %0d", dgr, exp_d); end
        n_cmp++;
        if (fgr != exp_f) begin n_err++; $display("FAIL starve_if_grants: got %0d want %0d", fgr, exp_f); end
        @(negedge iclk); clear_inputs();
    endtask

    task automatic test_wait_states();
        logic [36:0] exp_v;
        exp_v = {1'b1, 1'b0, 2'b01, 32'h3000, 1'b0};
        @(negedge iclk); idm_req = 1; idm_we = 0; idm_size = 2'b01; idm_addr = 32'h3000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge iclk);
            imem_rvalid = (c == 2);
            imem_gnt    = (c == 4);
            if (c == 2) idm_addr = 32'h3FFC;
            #1; n_cmp++;
            if ({omem_req, omem_we, omem_size, omem_addr, odm_rvalid} !== exp_v) begin
                n_err++; $display("FAIL wait_req_c%0d: got %h want %h", c, {omem_req, omem_we, omem_size, omem_addr, odm_rvalid}, exp_v);
            end
            n_cmp++;
            if (odm_gnt !== (c == 4)) begin n_err++; $display("FAIL wait_gnt_c%0d: got %b want %b", c, odm_gnt, (c == 4)); end
        end
        @(negedge iclk); idm_req = 0; imem_gnt = 0;
        for (int c = 5; c <= 6; c++) begin
            #1; n_cmp++;
            if ({omem_req, odm_rvalid} !== 2'b00) begin n_err++; $display("FAIL wait_rsp_c%0d: got %b want 00", c, {omem_req, odm_rvalid}); end
            @(negedge iclk);
        end
        imem_rvalid = 1; imem_rdata = 32'hCAFEF00D;
        #1; n_cmp++;
        if ({odm_rvalid, odm_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL wait_rdata: got %h want %h", {odm_rvalid, odm_rdata}, {1'b1, 32'hCAFEF00D});
        end
        @(negedge iclk); clear_inputs();
    endtask

    task automatic test_reset_in_rsp();
        @(negedge iclk); iif_req = 1; iif_addr = 32'h40; imem_gnt = 1;
        @(negedge iclk); #1; n_cmp++;
        if (oif_gnt !== 1'b1) begin n_err++; $display("FAIL rrsp_gnt: got %b want 1", oif_gnt); end
        @(negedge iclk); iif_req = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h55;
        #1; n_cmp++;
        if (oif_rvalid !== 1'b1) begin n_err++; $display("FAIL rrsp_in_rsp: got %b want 1", oif_rvalid); end
        #1; irstn = 0;
        #1; n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL rrsp_async: got %h want 0", all_out); end
        @(negedge iclk); irstn = 1;
        for (int c = 0; c < 2; c++) begin
            #1; n_cmp++;
            if ({oif_rvalid, odm_rvalid} !== 2'b00) begin
                n_err++; $display("FAIL rrsp_late_rvalid%0d: got %b want 00", c, {oif_rvalid, odm_rvalid});
            end
            @(negedge iclk);
        end
        clear_inputs();
    endtask

    // Transaction-level model: one owner at a time, memory contents tracked in an array.
    task automatic test_random(input int ncyc);
        logic          f_pend = 0, d_pend = 0, d_we = 0, own_dm = 0, t_we = 0, g, rv;
        logic [31:0]   f_addr = 0, d_addr = 0, t_addr = 0, d_wdata = 0, t_wdata = 0, exp_rd = 0, rd;
        logic [1:0]    d_size = 0, t_size = 0;
        logic [31:0]   mem_m [16];
        int            busy = 0;
        int            lat = 0;
        int            starve = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge iclk);
            if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_pend = 1; f_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_pend && $urandom_range(0, 1) == 0) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 3));
                d_addr = 32'($urandom_range(0, 15)) << 2; d_wdata = $urandom;
            end
            g  = (busy == 1) && ($urandom_range(0, 2) != 0);
            rv = (busy == 2) ? (lat == 0) : ($urandom_range(0, 7) == 0);
            rd = (busy == 2 && lat == 0) ? exp_rd : $urandom;
            iif_req = f_pend; iif_addr = f_addr;
            idm_req = d_pend; idm_we = d_we; idm_size = d_size; idm_addr = d_addr; idm_wdata = d_wdata;
            imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
            #1; n_cmp++;
            if (omem_req !== (busy == 1)) begin n_err++; $display("FAIL rnd_req cyc%0d: got %b want %b", cyc, omem_req, (busy == 1)); end
            if (busy == 1) begin
                n_cmp++;
                if ({omem_we, omem_size, omem_addr, omem_wdata} !== {t_we, t_size, t_addr, t_wdata}) begin
                    n_err++; $display("FAIL rnd_fields cyc%0d: got %h want %h", cyc,
                                      {omem_we, omem_size, omem_addr, omem_wdata}, {t_we, t_size, t_addr, t_wdata});
                end
            end
            n_cmp++;
            if ({oif_gnt, odm_gnt} !== {(busy == 1) && g && !own_dm, (busy == 1) && g && own_dm}) begin
                n_err++; $display("FAIL rnd_gnt cyc%0d: got %b want %b", cyc, {oif_gnt, odm_gnt},
                                  {(busy == 1) && g && !own_dm, (busy == 1) && g && own_dm});
            end
            n_cmp++;
            if ({oif_rvalid, odm_rvalid} !== {(busy == 2) && rv && !own_dm, (busy == 2) && rv && own_dm}) begin
                n_err++; $display("FAIL rnd_rvalid cyc%0d: got %b want %b", cyc, {oif_rvalid, odm_rvalid},
                                  {(busy == 2) && rv && !own_dm, (busy == 2) && rv && own_dm});
            end
            if (busy == 2 && rv) begin
                n_cmp++;
                if ((own_dm ? odm_rdata : oif_rdata) !== exp_rd) begin
                    n_err++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, (own_dm ? odm_rdata : oif_rdata), exp_rd);
                end
            end
            if (busy == 0) begin
                if (f_pend || d_pend) begin
                    own_dm = d_pend && !(f_pend && GUARD && starve == SMAX);
                    if (own_dm) begin
                        t_we = d_we; t_size = d_size; t_addr = d_addr; t_wdata = d_wdata;
                    end else begin
                        t_we = 0; t_size = 2'b10; t_addr = f_addr; t_wdata = '0;
                    end
                    busy = 1;
                end
            end else if (busy == 1) begin
                if (g) begin
                    if (own_dm) begin
                        d_pend = 0; starve = f_pend ? starve + 1 : 0;
                    end else begin
                        f_pend = 0; starve = 0;
                    end
                    if (t_we) begin
                        mem_m[t_addr[5:2]] = t_wdata; busy = 0;
                    end else begin
                        exp_rd = mem_m[t_addr[5:2]]; lat = $urandom_range(0, 2); busy = 2;
                    end
                end
            end else begin
                if (rv) busy = 0;
                else lat--;
            end
        end
        @(negedge iclk); clear_inputs();
    endtask

    initial begin
        irstn = 0;
        clear_inputs();
        test_reset();
        do_reset(); test_fetch_only();
        do_reset(); test_write();
        do_reset(); test_collision();
        do_reset(); test_starvation();
        do_reset(); test_wait_states();
        do_reset(); test_reset_in_rsp();
        do_reset(); test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and data-memory port. Requests are accepted with a req/gnt handshake, one transaction at a time is issued to memory, and read responses are routed back to their owner. The core stalls through withheld grants. The block sits between the `riscv` core's fetch/data ports and the memory-side bus.

## Interface
Parameters:
- MP_DATA_WIDTH, 32, data bus width.
- MP_STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending (guard build only); range 1..15.

Ports:
- iclk  in  1  clock; all state is updated on the rising edge.
- irstn  in  1  asynchronous, active-low reset.
- iif_req  in  1  fetch request; held with its address stable until oif_gnt.
- iif_addr  in  32  fetch address.
- oif_gnt  out  1  fetch accepted by memory.
- oif_rvalid  out  1  fetch data valid.
- oif_rdata  out  MP_DATA_WIDTH  fetch data.
- idm_req  in  1  data request; held with its fields stable until odm_gnt.
- idm_we  in  1  1 = write, 0 = read.
- idm_size  in  2  access size code, passed through unchanged.
- idm_addr  in  32  data address.
- idm_wdata  in  MP_DATA_WIDTH  write data.
- odm_gnt  out  1  data request accepted.
- odm_rvalid  out  1  load data valid.
- odm_rdata  out  MP_DATA_WIDTH  load data.
- omem_req / omem_we  out  1 / 1  memory request and write enable.
- omem_size  out  2  memory access size code.
- omem_addr  out  32  memory address.
- omem_wdata  out  MP_DATA_WIDTH  memory write data.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  MP_DATA_WIDTH  read data.

## Operation
- FSM states: IDLE, REQ, RSP. Owner register: IF or DM.
- IDLE, at least one request present: arbitrate, latch the winner's we/size/addr/wdata into the issue registers (fetch: we=0, size=2'b10, wdata=0), set owner, go to REQ.
- Arbitration: data wins over fetch; the exception is set by the starvation guard (see Configuration).
- REQ: omem_req=1 and omem_* are driven from the issue registers. On imem_gnt, pulse the owner's gnt (combinational, same cycle). After the grant, a write goes to IDLE and a read goes to RSP.
- RSP: omem_req=0. On imem_rvalid, drive the owner's rvalid=1 and rdata=imem_rdata (combinational), then go to IDLE.
- Non-owner gnt and rvalid stay 0. An imem_rvalid seen in IDLE or REQ is ignored.
- Only one transaction is outstanding at a time. The loser's request stays pending and is arbitrated again in the next IDLE cycle.
- Reset values: state=IDLE, owner=IF, all issue registers 0, starvation counter 0, every output 0.

## Timing
- A request seen in IDLE at cycle N drives omem_req from cycle N+1. The earliest gnt is at N+1 (imem_gnt same cycle).
- Minimum read occupancy is 3 cycles: IDLE, REQ, RSP with rvalid. The next arbitration follows in the IDLE cycle after that.
- Minimum write occupancy is 2 cycles.
- Simultaneous fetch and data requests in IDLE: data is issued first; fetch is issued in the IDLE cycle after the data transaction completes.
- Reset asserted mid-transaction aborts it at once: outputs go to 0 asynchronously, and a later imem_rvalid is ignored. After irstn deasserts, the first arbitration happens on the first rising edge.
- Requester fields change before gnt: the block has already latched them in IDLE and the change has no effect on the issued transaction.

## Configuration
- RISCV_ARB_STARVE_GUARD_EN defined:
  - The counter increments on each data grant issued while iif_req=1.
  - It clears on a fetch grant, or on a data grant issued with iif_req=0.
  - When the counter equals MP_STARVE_MAX and both requests are present, the fetch wins.
- Not defined: strict data priority. The counter logic is absent and a fetch can starve indefinitely.

## Test plan
- Fetch only: iif_addr=0x100, memory grants at once and returns 0x00500093 one cycle later -> omem_addr=0x100, omem_we=0; oif_gnt at cycle 1; oif_rvalid=1 with oif_rdata=0x00500093 at cycle 2; odm_* stay 0.
- Data write: idm_addr=0x2000, idm_wdata=0xDEADBEEF, idm_size=2'b10 -> one omem_req cycle with omem_we=1 and matching fields; odm_gnt pulses; no rvalid on either port; FSM back in IDLE after 2 cycles.
- Collision: fetch (0x104) and load (0x2004) requested in the same IDLE cycle -> load issued first and its data returns on odm_rdata; fetch issued immediately after and returns on oif_rdata.
- Starvation, guard defined, MP_STARVE_MAX=4: fetch held high while data requests back-to-back -> exactly 4 data grants, then the fetch is granted. Guard undefined -> no fetch grant during a 20-transaction data burst.
- Memory wait states: imem_gnt delayed 3 cycles, imem_rvalid delayed 2 more -> omem_req held steady with fixed fields; no early gnt; a stray imem_rvalid during REQ is ignored.
- Reset in RSP: irstn pulled low while awaiting rvalid -> all outputs 0 immediately; after release, an imem_rvalid produces no oif_rvalid or odm_rvalid.
